rx_frame_checker: RTL and testbench
===================================

# rx_frame_checker

Receive-side frame checker for the Ethernet pattern test path. It consumes the byte-wide AXI-Stream receive output of the tri-mode MAC and parses the 14-byte header (DA, SA, length). It checks payload bytes against the incrementing pattern produced by the transmit generator, and reports per-frame status along with saturating good/bad frame counters.

## Interface
- MAX_PAYLOAD, 1500: largest legal value of the length field.
- CHECK_DA, 1: 1 = enforce destination-address filtering; 0 = `err_addr` is never set.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_tdata  in  8  received byte.
- rx_tvalid  in  1  byte valid.
- rx_tlast  in  1  last byte of frame.
- rx_tuser  in  1  MAC bad-frame flag; sampled only on the tlast beat.
- rx_tready  out  1  accept; 0 in reset, 1 otherwise.
- my_mac  in  48  station address; byte 0 of the frame is `my_mac[47:40]`.
- clear_stats  in  1  synchronous clear of both counters.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_ok  out  1  last frame had no error.
- err_short, err_len, err_data, err_addr, err_fcs  out  1 each  per-frame error flags for the last frame.
- rx_len  out  16  length field of the last frame; 0 if the frame was short.
- good_count, bad_count  out  16 each  saturating frame counters.

## Operation
- Beat accepted when `rx_tvalid & rx_tready`. Idle cycles (tvalid=0) freeze all state.
- A 16-bit byte index counts accepted beats from 0 and saturates at 0xFFFF. It returns to 0 after a tlast beat.
- States:
  - HDR: indices 0..13. Bytes 0-5 are the DA, bytes 6-11 the SA (ignored), byte 12 is the length MSB and byte 13 the length LSB. Index 13 accepted → PAY. tlast in HDR → HDR with a result.
  - PAY: index ≥14; payload index p = index−14. tlast → HDR with a result.
- Reset state is HDR. The beat after any tlast is the start of a new frame.
- DA check: accumulate a DA mismatch bit over bytes 0-5. `err_addr` = CHECK_DA & DA≠`my_mac` & DA≠FF:FF:FF:FF:FF:FF.
- Data check: for p < length field, the payload byte must equal p[7:0]. Any mismatch sets `err_data`. Bytes with p ≥ length are not data-checked.
- Length check: `err_len` = (length field > MAX_PAYLOAD) | (payload byte count ≠ length field) | (byte index saturated).
- Short frame: tlast at index <13 sets `err_short`. In that case `err_len`, `err_data` and `err_addr` are all 0, and `rx_len` = 0.
- `err_fcs` = `rx_tuser` on the tlast beat, independent of the other errors.
- `frame_ok` = no error flag set.
- Counters: `good_count` increments when `frame_ok`; otherwise `bad_count` increments. Both saturate at 0xFFFF and never wrap.
- `clear_stats` zeroes both counters. If it coincides with an increment, clear wins and the result is 0.

## Timing
- `frame_done` is high for exactly the cycle after the tlast handshake.
- The status flags and `rx_len` are registered and update in the same cycle as `frame_done`. They then hold until the next `frame_done`.
- Counters update in the same cycle as `frame_done`.
- Full-rate back-to-back frames are supported. A new frame's first byte may arrive in the cycle immediately after tlast, including the cycle in which `frame_done` is high, with no lost bytes.
- Reset (asynchronous assert, any time, including mid-frame): state → HDR, index 0, accumulated errors cleared. All outputs go to 0 (`rx_tready` 0, `frame_done` 0, `frame_ok` 0, all flags 0, `rx_len` 0, counters 0). The remainder of an interrupted frame is parsed as a new frame and counted bad.
- Deassertion is synchronised by the integrator. `rx_tready` rises on the first clock edge after `rst_n` goes high.

## Test plan
- Good frame: DA=`my_mac`, length 0x0004, payload 00 01 02 03, tlast on the 18th byte → next cycle `frame_done`=1, `frame_ok`=1, `rx_len`=4, `good_count`=1.
- Same frame with payload byte 2 = 0x55 → `err_data`=1, `frame_ok`=0, `bad_count`=1. Repeat with length field 10 but 8 payload bytes → `err_len`=1. Repeat with length 0x05DD and CHECK_DA=1 → `err_len`=1.
- 10-byte frame with tlast on byte 10 → `err_short`=1, `rx_len`=0, other flags 0. Then an immediate good frame → `frame_ok`=1.
- DA=FF:FF:FF:FF:FF:FF → `frame_ok`=1. DA=02:00:00:00:00:01 ≠ `my_mac` → `err_addr`=1 (CHECK_DA=1); 0 with CHECK_DA=0. `rx_tuser`=1 on the tlast of a good frame → only `err_fcs`=1.
- Random tvalid gaps plus back-to-back good frames → one `frame_done` per frame, all `frame_ok`, `good_count` equals the frame count.
- Reset asserted at payload byte 3 → all outputs 0 immediately. The trailing bytes of the cut frame → `bad_count`=1. The next full frame → `good_count`=1. `clear_stats` in the same cycle as `frame_done` → both counters read 0.

Source files
------------

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: parses DA/SA/length of byte-wide receive frames and checks the
//   payload against the incrementing 00,01,02.. pattern; per-frame status plus counters.
// Latency: status, rx_len and counters update one cycle after the tlast handshake.
// Backpressure: none; rx_tready is 0 only in reset, so every valid beat is consumed.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_tdata/tvalid/tlast/tuser byte stream from the MAC (tuser = bad FCS, tlast beat only)
//   rx_tready                  accept, 1 whenever out of reset
//   my_mac                     station address, frame byte 0 = my_mac[47:40]
//   clear_stats                synchronous clear of good_count/bad_count
//   frame_done                 one-cycle pulse per completed frame
//   frame_ok, err_*            status of the last completed frame
//   rx_len                     length field of the last frame (0 if short)
//   good_count, bad_count      saturating frame counters
module rx_frame_checker #(
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter bit          CHECK_DA    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  output logic        rx_tready,
  input  logic [47:0] my_mac,
  input  logic        clear_stats,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_short,
  output logic        err_len,
  output logic        err_data,
  output logic        err_addr,
  output logic        err_fcs,
  output logic [15:0] rx_len,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  localparam logic [15:0] HDR_LAST = 16'd13;
  localparam logic [15:0] PAY_BASE = 16'd14;
  localparam logic [15:0] IDX_MAX  = 16'hFFFF;
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);

  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] len_q, len_d;
  logic        da_ne_mac_q, da_ne_mac_d;
  logic        da_ne_bc_q, da_ne_bc_d;
  logic        data_err_q, data_err_d;
  logic        rdy_q;

  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        short_q, short_d;
  logic        elen_q, elen_d;
  logic        edata_q, edata_d;
  logic        eaddr_q, eaddr_d;
  logic        efcs_q, efcs_d;
  logic [15:0] rx_len_q, rx_len_d;
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;

  logic        beat, last_beat;
  logic        in_da, in_pay;
  logic [7:0]  mac_byte;
  logic [15:0] pay_idx;
  logic [15:0] pay_cnt;
  logic [15:0] len_cur;
  logic        da_mis_mac, da_mis_bc, data_mis;
  logic        res_short, res_len, res_data, res_addr, res_ok;

  assign beat      = rx_tvalid & rdy_q;
  assign last_beat = beat & rx_tlast;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (beat) begin
      if (rx_tlast) begin
        state_d = ST_HDR;
      end else if (state_q == ST_HDR && idx_q == HDR_LAST) begin
        state_d = ST_PAY;
      end
    end
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    in_da  = (state_q == ST_HDR) && (idx_q < 16'd6);
    in_pay = (state_q == ST_PAY);
  end

  // Expected DA byte for the current header index.
  always_comb begin
    mac_byte = 8'h00;
    case (idx_q[2:0])
      3'd0:    mac_byte = my_mac[47:40];
      3'd1:    mac_byte = my_mac[39:32];
      3'd2:    mac_byte = my_mac[31:24];
      3'd3:    mac_byte = my_mac[23:16];
      3'd4:    mac_byte = my_mac[15:8];
      3'd5:    mac_byte = my_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // Per-beat checks and the frame result evaluated on the tlast beat.
  always_comb begin
    pay_idx    = idx_q - PAY_BASE;
    // Number of payload bytes including the current (tlast) beat.
    pay_cnt    = idx_q - HDR_LAST;
    // A frame ending on byte 13 has its length LSB on the wire right now.
    len_cur    = (idx_q == HDR_LAST) ? {len_q[15:8], rx_tdata} : len_q;
    da_mis_mac = in_da && (rx_tdata != mac_byte);
    da_mis_bc  = in_da && (rx_tdata != 8'hFF);
    data_mis   = in_pay && (pay_idx < len_q) && (rx_tdata != pay_idx[7:0]);

    res_short  = (idx_q < HDR_LAST);
    // DA bytes are all behind us for any non-short frame, so the
    // accumulators alone decide the address result.
    res_addr   = !res_short && CHECK_DA && da_ne_mac_q && da_ne_bc_q;
    res_len    = !res_short && ((len_cur > MAX_LEN) || (pay_cnt != len_cur) ||
                                (idx_q == IDX_MAX));
    res_data   = !res_short && (data_err_q || data_mis);
    res_ok     = !(res_short || res_len || res_data || res_addr || rx_tuser);
  end

  // Parser datapath: index, length field, running error accumulators.
  always_comb begin
    idx_d       = idx_q;
    len_d       = len_q;
    da_ne_mac_d = da_ne_mac_q;
    da_ne_bc_d  = da_ne_bc_q;
    data_err_d  = data_err_q;
    if (beat) begin
      if (rx_tlast) begin
        idx_d       = 16'd0;
        da_ne_mac_d = 1'b0;
        da_ne_bc_d  = 1'b0;
        data_err_d  = 1'b0;
      end else begin
        idx_d       = (idx_q == IDX_MAX) ? idx_q : idx_q + 16'd1;
        da_ne_mac_d = da_ne_mac_q | da_mis_mac;
        da_ne_bc_d  = da_ne_bc_q | da_mis_bc;
        data_err_d  = data_err_q | data_mis;
      end
      if (state_q == ST_HDR && idx_q == 16'd12) len_d[15:8] = rx_tdata;
      if (state_q == ST_HDR && idx_q == HDR_LAST) len_d[7:0] = rx_tdata;
    end
  end

  // Registered status outputs and counters.
  always_comb begin
    done_d   = last_beat;
    ok_d     = ok_q;
    short_d  = short_q;
    elen_d   = elen_q;
    edata_d  = edata_q;
    eaddr_d  = eaddr_q;
    efcs_d   = efcs_q;
    rx_len_d = rx_len_q;
    good_d   = good_q;
    bad_d    = bad_q;
    if (last_beat) begin
      ok_d     = res_ok;
      short_d  = res_short;
      elen_d   = res_len;
      edata_d  = res_data;
      eaddr_d  = res_addr;
      efcs_d   = rx_tuser;
      rx_len_d = res_short ? 16'd0 : len_cur;
      if (res_ok) begin
        if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
      end else begin
        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
      end
    end
    // Clear takes priority over a coincident increment.
    if (clear_stats) begin
      good_d = 16'd0;
      bad_d  = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 16'd0;
      len_q       <= 16'd0;
      da_ne_mac_q <= 1'b0;
      da_ne_bc_q  <= 1'b0;
      data_err_q  <= 1'b0;
      rdy_q       <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      short_q     <= 1'b0;
      elen_q      <= 1'b0;
      edata_q     <= 1'b0;
      eaddr_q     <= 1'b0;
      efcs_q      <= 1'b0;
      rx_len_q    <= 16'd0;
      good_q      <= 16'd0;
      bad_q       <= 16'd0;
    end else begin
      idx_q       <= idx_d;
      len_q       <= len_d;
      da_ne_mac_q <= da_ne_mac_d;
      da_ne_bc_q  <= da_ne_bc_d;
      data_err_q  <= data_err_d;
      rdy_q       <= 1'b1;
      done_q      <= done_d;
      ok_q        <= ok_d;
      short_q     <= short_d;
      elen_q      <= elen_d;
      edata_q     <= edata_d;
      eaddr_q     <= eaddr_d;
      efcs_q      <= efcs_d;
      rx_len_q    <= rx_len_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign rx_tready  = rdy_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign err_short  = short_q;
  assign err_len    = elen_q;
  assign err_data   = edata_q;
  assign err_addr   = eaddr_q;
  assign err_fcs    = efcs_q;
  assign rx_len     = rx_len_q;
  assign good_count = good_q;
  assign bad_count  = bad_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: scoreboard bench for rx_frame_checker. Expected per-frame
//   results are computed from the frame bytes when a frame is queued and compared
//   when frame_done fires; feature tasks add their own inline checks.
module tb_rx_frame_checker;

  localparam int          MAX_PAYLOAD = 1500;
  localparam logic [47:0] MY_MAC      = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] BCAST       = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER_MAC   = 48'h020000000001;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic        ok;
    logic        sh;
    logic        ln;
    logic        dt;
    logic        ad;
    logic        fc;
    logic        ok_nda;
    logic        clr;
    logic [15:0] len;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tuser;
  logic        rx_tready;
  logic [47:0] my_mac;
  logic        clear_stats;
  logic        frame_done, frame_ok;
  logic        err_short, err_len, err_data, err_addr, err_fcs;
  logic [15:0] rx_len, good_count, bad_count;

  logic        n_tready, n_done, n_ok, n_short, n_len, n_data, n_addr, n_fcs;
  logic [15:0] n_rx_len, n_good, n_bad;

  int          checks = 0;
  int          errors = 0;
  int          n_frames_done = 0;
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_bad  = 16'd0;
  logic        clr_on_last = 1'b0;
  res_t        sb[$];
  res_t        mon_e;

  rx_frame_checker #(.MAX_PAYLOAD(MAX_PAYLOAD), .CHECK_DA(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser), .rx_tready(rx_tready),
    .my_mac(my_mac), .clear_stats(clear_stats), .frame_done(frame_done),
    .frame_ok(frame_ok), .err_short(err_short), .err_len(err_len),
    .err_data(err_data), .err_addr(err_addr), .err_fcs(err_fcs),
    .rx_len(rx_len), .good_count(good_count), .bad_count(bad_count)
  );

  // Same stream, DA filtering disabled.
  rx_frame_checker #(.MAX_PAYLOAD(MAX_PAYLOAD), .CHECK_DA(1'b0)) u_dut_nda (
    .clk(clk), .rst_n(rst_n), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .rx_tuser(rx_tuser), .rx_tready(n_tready),
    .my_mac(my_mac), .clear_stats(clear_stats), .frame_done(n_done),
    .frame_ok(n_ok), .err_short(n_short), .err_len(n_len),
    .err_data(n_data), .err_addr(n_addr), .err_fcs(n_fcs),
    .rx_len(n_rx_len), .good_count(n_good), .bad_count(n_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Frame builder: DA, SA 10..15, length field, npay incrementing payload bytes.
  function automatic byte_q_t mk_frame(input logic [47:0] da, input int lenf, input int npay);
    byte_q_t q;
    logic [15:0] lf;
    lf = 16'(lenf);
    for (int i = 0; i < 6; i++) q.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) q.push_back(8'(16 + i));
    q.push_back(lf[15:8]);
    q.push_back(lf[7:0]);
    for (int p = 0; p < npay; p++) q.push_back(8'(p));
    return q;
  endfunction

  // Reference result for a whole frame as seen on the wire.
  function automatic res_t model(input byte_q_t b, input logic tuser);
    res_t r;
    int n;
    logic [15:0] lf;
    logic ne_mac, ne_bc;
    logic [47:0] mac;
    r = '0;
    mac = my_mac;
    n = b.size();
    r.fc = tuser;
    if (n < 14) begin
      r.sh = 1'b1;
    end else begin
      lf = {b[12], b[13]};
      r.len = lf;
      if (int'(lf) > MAX_PAYLOAD || (n - 14) != int'(lf)) r.ln = 1'b1;
      for (int p = 0; p < n - 14 && p < int'(lf); p++)
        if (b[14+p] != 8'(p)) r.dt = 1'b1;
      ne_mac = 1'b0;
      ne_bc  = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (b[i] != mac[47-8*i -: 8]) ne_mac = 1'b1;
        if (b[i] != 8'hFF) ne_bc = 1'b1;
      end
      r.ad = ne_mac & ne_bc;
    end
    r.ok     = !(r.sh | r.ln | r.dt | r.ad | r.fc);
    r.ok_nda = !(r.sh | r.ln | r.dt | r.fc);
    return r;
  endfunction

  // Drives one frame starting at posedge+1; returns at posedge+1 with tvalid low.
  // During idle gaps tdata/tlast are randomised to show they are ignored.
  task automatic send_frame(input byte_q_t b, input logic tuser, input int gap_max);
    res_t e;
    int g;
    e = model(b, tuser);
    e.clr = clr_on_last;
    sb.push_back(e);
    for (int i = 0; i < b.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        rx_tvalid = 1'b0;
        rx_tlast  = 1'($urandom_range(1, 0));
        rx_tdata  = 8'($urandom);
        @(posedge clk); #1;
      end
      rx_tvalid   = 1'b1;
      rx_tdata    = b[i];
      rx_tlast    = (i == b.size() - 1);
      rx_tuser    = rx_tlast ? tuser : 1'($urandom_range(1, 0));
      clear_stats = rx_tlast ? clr_on_last : 1'b0;
      @(posedge clk); #1;
    end
    rx_tvalid   = 1'b0;
    rx_tlast    = 1'b0;
    rx_tuser    = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic wait_sb();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_frame_done: timeout, pending=%0d required=0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: pops one expected result per frame_done.
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got frame_done=1 with no frame pending");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.clr) begin
          exp_good = 16'd0;
          exp_bad  = 16'd0;
        end else if (mon_e.ok) begin
          exp_good = exp_good + 16'd1;
        end else begin
          exp_bad = exp_bad + 16'd1;
        end
        n_frames_done++;
        checks++;
        if ({frame_ok, err_short, err_len, err_data, err_addr, err_fcs, rx_len} !==
            {mon_e.ok, mon_e.sh, mon_e.ln, mon_e.dt, mon_e.ad, mon_e.fc, mon_e.len})
          begin
          errors++;
          $display("FAIL frame_status: ok/short/len/data/addr/fcs=%b%b%b%b%b%b rx_len=%0d, required %b%b%b%b%b%b rx_len=%0d",
                   frame_ok, err_short, err_len, err_data, err_addr, err_fcs, rx_len,
                   mon_e.ok, mon_e.sh, mon_e.ln, mon_e.dt, mon_e.ad, mon_e.fc, mon_e.len);
        end
        checks++;
        if ({good_count, bad_count} !== {exp_good, exp_bad}) begin
          errors++;
          $display("FAIL counters: good=%0d bad=%0d, required good=%0d bad=%0d",
                   good_count, bad_count, exp_good, exp_bad);
        end
        checks++;
        if ({n_done, n_addr, n_ok} !== {1'b1, 1'b0, mon_e.ok_nda}) begin
          errors++;
          $display("FAIL no_da_check: done/err_addr/ok=%b%b%b, required 1 0 %b",
                   n_done, n_addr, n_ok, mon_e.ok_nda);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    rx_tvalid = 1'b0; rx_tdata = 8'h00; rx_tlast = 1'b0; rx_tuser = 1'b0;
    clear_stats = 1'b0; my_mac = MY_MAC;
    #12;
    checks++;
    if ({rx_tready, frame_done, frame_ok, err_short, err_len, err_data, err_addr, err_fcs,
         rx_len, good_count, bad_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tready=%b done=%b ok=%b rx_len=%0d good=%0d bad=%0d, required all 0",
               rx_tready, frame_done, frame_ok, rx_len, good_count, bad_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rx_tready !== 1'b0) begin
      errors++;
      $display("FAIL tready_before_edge: got %b required 0", rx_tready);
    end
    @(posedge clk); #1;
    checks++;
    if (rx_tready !== 1'b1) begin
      errors++;
      $display("FAIL tready_after_edge: got %b required 1", rx_tready);
    end
  endtask

  task automatic test_good();
    byte_q_t f;
    f = mk_frame(MY_MAC, 4, 4);
    send_frame(f, 1'b0, 0);
    wait_sb();
    f = mk_frame(MY_MAC, 0, 0);              // header-only frame, tlast on byte 13
    send_frame(f, 1'b0, 0);
    f = mk_frame(MY_MAC, 1500, 1500);        // largest legal length
    send_frame(f, 1'b0, 0);
    wait_sb();
  endtask

  task automatic test_data_err();
    byte_q_t f;
    f = mk_frame(MY_MAC, 4, 4);
    f[16] = 8'h55;
    send_frame(f, 1'b0, 0);
    wait_sb();
  endtask

  task automatic test_len();
    byte_q_t f;
    f = mk_frame(MY_MAC, 10, 8);
    send_frame(f, 1'b0, 0);
    f = mk_frame(MY_MAC, 16'h05DD, 16'h05DD);
    send_frame(f, 1'b0, 0);
    f = mk_frame(MY_MAC, 2, 4);              // bytes past the length are not data-checked
    f[16] = 8'hAA;
    f[17] = 8'hBB;
    send_frame(f, 1'b0, 0);
    wait_sb();
  endtask

  task automatic test_short();
    byte_q_t f;
    f = mk_frame(MY_MAC, 4, 4);
    while (f.size() > 11) void'(f.pop_back());   // tlast on index 10
    send_frame(f, 1'b0, 0);
    f = mk_frame(MY_MAC, 4, 4);
    while (f.size() > 13) void'(f.pop_back());   // tlast on index 12, still short
    send_frame(f, 1'b0, 0);
    f = mk_frame(MY_MAC, 4, 4);
    send_frame(f, 1'b0, 0);
    wait_sb();
  endtask

  task automatic test_addr_fcs();
    byte_q_t f;
    int fd;
    f = mk_frame(BCAST, 6, 6);
    send_frame(f, 1'b0, 0);
    f = mk_frame(OTHER_MAC, 6, 6);
    send_frame(f, 1'b0, 0);
    f = mk_frame(MY_MAC, 5, 5);
    send_frame(f, 1'b1, 0);
    wait_sb();
    // Idle with garbage on tdata/tlast: nothing may change.
    fd = 0;
    repeat (6) begin
      rx_tvalid = 1'b0;
      rx_tlast  = 1'($urandom_range(1, 0));
      rx_tdata  = 8'($urandom);
      @(negedge clk);
      if (frame_done) fd++;
      @(posedge clk); #1;
    end
    rx_tlast = 1'b0;
    checks++;
    if (fd !== 0 || {frame_ok, err_short, err_len, err_data, err_addr, err_fcs, rx_len} !==
        {6'b000001, 16'd5}) begin
      errors++;
      $display("FAIL idle_hold: done_pulses=%0d flags=%b%b%b%b%b%b rx_len=%0d, required 0 pulses flags=000001 rx_len=5",
               fd, frame_ok, err_short, err_len, err_data, err_addr, err_fcs, rx_len);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t f;
    int d0;
    logic [15:0] g0;
    int np;
    d0 = n_frames_done;
    g0 = good_count;
    for (int k = 0; k < 20; k++) begin
      np = int'($urandom_range(40, 0));
      f = mk_frame((k % 3 == 0) ? BCAST : MY_MAC, np, np);
      send_frame(f, 1'b0, (k < 10) ? 3 : 0);
    end
    wait_sb();
    checks++;
    if (n_frames_done - d0 !== 20) begin
      errors++;
      $display("FAIL b2b_frame_count: got %0d frame_done pulses required 20", n_frames_done - d0);
    end
    checks++;
    if (good_count !== g0 + 16'd20) begin
      errors++;
      $display("FAIL b2b_good_count: got %0d required %0d", good_count, g0 + 16'd20);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t f, tail;
    f = mk_frame(MY_MAC, 8, 8);
    for (int i = 0; i < 17; i++) begin       // up to payload byte 2
      rx_tvalid = 1'b1;
      rx_tdata  = f[i];
      rx_tlast  = 1'b0;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    rx_tvalid = 1'b0;
    #1;
    checks++;
    if ({rx_tready, frame_done, frame_ok, err_short, err_len, err_data, err_addr, err_fcs,
         rx_len, good_count, bad_count} !== '0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: tready=%b ok=%b rx_len=%0d good=%0d bad=%0d, required all 0",
               rx_tready, frame_ok, rx_len, good_count, bad_count);
    end
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 17; i < f.size(); i++) tail.push_back(f[i]);
    send_frame(tail, 1'b0, 0);               // remainder parses as a short frame
    wait_sb();
    checks++;
    if (bad_count !== 16'd1) begin
      errors++;
      $display("FAIL cut_frame_bad_count: got %0d required 1", bad_count);
    end
    f = mk_frame(MY_MAC, 4, 4);
    send_frame(f, 1'b0, 0);
    wait_sb();
    checks++;
    if (good_count !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_good_count: got %0d required 1", good_count);
    end
  endtask

  task automatic test_clear_stats();
    byte_q_t f;
    f = mk_frame(MY_MAC, 4, 4);
    clr_on_last = 1'b1;                      // clear coincides with the increment
    send_frame(f, 1'b0, 0);
    clr_on_last = 1'b0;
    wait_sb();
    send_frame(f, 1'b0, 0);
    f[15] = 8'h77;
    send_frame(f, 1'b0, 0);
    wait_sb();
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    exp_good = 16'd0;
    exp_bad  = 16'd0;
    checks++;
    if ({good_count, bad_count} !== 32'd0) begin
      errors++;
      $display("FAIL idle_clear: good=%0d bad=%0d required 0 0", good_count, bad_count);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_data_err();
    test_len();
    test_short();
    test_addr_fcs();
    test_back_to_back();
    test_reset_mid();
    test_clear_stats();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
